// File: rtl/serv_bufreg_wide.sv
// Serial address/operand buffer: adds rs1+imm W bits per beat into a 32-bit shift register, or shifts it right.
// State updates one cycle after each enabled beat; o_q/o_last are combinational; i_en low stalls everything.
module serv_bufreg_wide #(
    parameter int W   = 1,
    parameter int MDU = 0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_init,
    input  logic         i_cnt0,
    input  logic         i_mdu_op,
    input  logic         i_rs1_en,
    input  logic         i_imm_en,
    input  logic         i_clr_lsb,
    input  logic         i_sh_signed,
    input  logic [W-1:0] i_rs1,
    input  logic [W-1:0] i_imm,
    output logic [W-1:0] o_q,
    output logic [1:0]   o_lsb,
    output logic         o_last,
    output logic [31:0]  o_dbus_adr,
    output logic [31:0]  o_ext_rs1
);

    localparam int N  = 32 / W;
    localparam int CW = $clog2(N);

    logic [31:0]   data;
    logic          c_r;
    logic [1:0]    lsb;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_eff;
    logic [W-1:0]  rs1_g;
    logic [W-1:0]  imm_g;
    logic [W-1:0]  m;
    logic [W:0]    sum;
    logic [W-1:0]  q;
    logic          c;

    // Clearing bit 0 of the immediate only on the first beat drops address bit 0 (JALR target).
    assign m     = {{(W-1){1'b0}}, i_cnt0 & i_clr_lsb};
    assign rs1_g = i_rs1 & {W{i_rs1_en}};
    assign imm_g = i_imm & {W{i_imm_en}} & ~m;
    assign sum   = {1'b0, rs1_g} + {1'b0, imm_g} + {{W{1'b0}}, c_r};
    assign q     = sum[W-1:0];
    assign c     = sum[W];

    // The first beat of a word always counts as beat 0, so a stray counter resyncs on i_cnt0.
    assign cnt_eff = i_cnt0 ? '0 : cnt_r;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data  <= '0;
            c_r   <= 1'b0;
            cnt_r <= '0;
        end else begin
            c_r <= c & i_en;
            if (i_en) begin
                cnt_r <= cnt_eff + 1'b1;
                if (i_init)
                    data <= {q, data[31:W]};
                else
                    data <= {{W{data[31] & i_sh_signed}}, data[31:W]};
            end
        end
    end

    generate
        if (W >= 2) begin : g_lsb_wide
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    lsb <= 2'b00;
                else if (i_en & i_init & i_cnt0)
                    lsb <= q[1:0];
            end
        end else begin : g_lsb_serial
            logic lsb1_pend;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    lsb       <= 2'b00;
                    lsb1_pend <= 1'b0;
                end else if (i_en & i_init) begin
                    if (i_cnt0) begin
                        lsb[0]    <= q[0];
                        lsb1_pend <= 1'b1;
                    end else if (lsb1_pend) begin
                        lsb[1]    <= q[0];
                        lsb1_pend <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign o_q        = data[W-1:0] & {W{i_en}};
    assign o_lsb      = ((MDU == 1) & i_mdu_op) ? 2'b00 : lsb;
    assign o_last     = i_en & ~i_cnt0 & (cnt_r == CW'(N - 1));
    assign o_dbus_adr = {data[31:2], 2'b00};
    assign o_ext_rs1  = data;

endmodule

// File: tb/tb_serv_bufreg_wide.sv
module tb_serv_bufreg_wide;

    logic clk = 1'b0;
    logic rst_n;
    logic init, cnt0, mdu_op, rs1_en, imm_en, clr_lsb, sh_signed;
    logic en4, en2, en1;
    logic [3:0] rs1_4, imm_4, q_4;
    logic [1:0] rs1_2, imm_2, q_2;
    logic [0:0] rs1_1, imm_1, q_1;
    logic [1:0] lsb_4, lsb_2, lsb_1;
    logic last_4, last_2, last_1;
    logic [31:0] adr_4, adr_2, adr_1, ext_4, ext_2, ext_1;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    serv_bufreg_wide #(.W(4), .MDU(1)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en4), .i_init(init), .i_cnt0(cnt0),
        .i_mdu_op(mdu_op), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
        .i_sh_signed(sh_signed), .i_rs1(rs1_4), .i_imm(imm_4), .o_q(q_4), .o_lsb(lsb_4),
        .o_last(last_4), .o_dbus_adr(adr_4), .o_ext_rs1(ext_4));

    serv_bufreg_wide #(.W(2), .MDU(0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en2), .i_init(init), .i_cnt0(cnt0),
        .i_mdu_op(mdu_op), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
        .i_sh_signed(sh_signed), .i_rs1(rs1_2), .i_imm(imm_2), .o_q(q_2), .o_lsb(lsb_2),
        .o_last(last_2), .o_dbus_adr(adr_2), .o_ext_rs1(ext_2));

    serv_bufreg_wide #(.W(1), .MDU(0)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en1), .i_init(init), .i_cnt0(cnt0),
        .i_mdu_op(mdu_op), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr_lsb),
        .i_sh_signed(sh_signed), .i_rs1(rs1_1), .i_imm(imm_1), .o_q(q_1), .o_lsb(lsb_1),
        .o_last(last_1), .o_dbus_adr(adr_1), .o_ext_rs1(ext_1));

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] imm;
        logic        rs1_en;
        logic        imm_en;
        logic        clr;
        logic [31:0] exp_sum;
        logic [1:0]  exp_lsb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_beat(input int w, input logic en, input logic [31:0] r, input logic [31:0] i);
        en4 = 1'b0; en2 = 1'b0; en1 = 1'b0;
        rs1_4 = r[3:0]; imm_4 = i[3:0];
        rs1_2 = r[1:0]; imm_2 = i[1:0];
        rs1_1 = r[0];   imm_1 = i[0];
        case (w)
            4:       en4 = en;
            2:       en2 = en;
            default: en1 = en;
        endcase
    endtask

    function automatic logic get_last(input int w);
        case (w)
            4:       return last_4;
            2:       return last_2;
            default: return last_1;
        endcase
    endfunction

    function automatic logic [31:0] get_ext(input int w);
        case (w)
            4:       return ext_4;
            2:       return ext_2;
            default: return ext_1;
        endcase
    endfunction

    function automatic logic [31:0] get_adr(input int w);
        case (w)
            4:       return adr_4;
            2:       return adr_2;
            default: return adr_1;
        endcase
    endfunction

    function automatic logic [1:0] get_lsb(input int w);
        case (w)
            4:       return lsb_4;
            2:       return lsb_2;
            default: return lsb_1;
        endcase
    endfunction

    // One full init word, then one idle cycle; checks o_last fires on the final beat only.
    task automatic run_word(input int w, input logic [31:0] rs1, input logic [31:0] imm, input logic clr);
        int n;
        logic [31:0] lastv;
        n = 32 / w;
        lastv = '0;
        clr_lsb = clr;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            init = 1'b1;
            cnt0 = (b == 0);
            set_beat(w, 1'b1, rs1 >> (b * w), imm >> (b * w));
            #1;
            lastv[b] = get_last(w);
        end
        @(negedge clk);
        init = 1'b0;
        cnt0 = 1'b0;
        clr_lsb = 1'b0;
        set_beat(w, 1'b0, 32'h0, 32'h0);
        #1;
        chk($sformatf("last_pattern_w%0d", w), lastv, 32'h1 << (n - 1));
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 32'h0000_07FF, 1'b1, 1'b1, 1'b0, 32'h0000_17FF, 2'd3};
        vecs[1] = '{32'h0FFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 2'd0};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 2'd0};
        vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 1'b0, 32'h2345_6789, 2'd1};
        vecs[4] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 32'h0000_0007, 2'd3};
        vecs[5] = '{32'hAAAA_0000, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 2'd0};
        vecs[6] = '{32'hDEAD_BEEF, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 2'd3};

        rst_n = 1'b0;
        init = 1'b0; cnt0 = 1'b0; mdu_op = 1'b0; rs1_en = 1'b1; imm_en = 1'b1;
        clr_lsb = 1'b0; sh_signed = 1'b0;
        set_beat(4, 1'b0, 32'h0, 32'h0);
        #12;
        chk("reset_ext4", ext_4, 32'h0);
        chk("reset_adr4", adr_4, 32'h0);
        chk("reset_lsb4", {30'h0, lsb_4}, 32'h0);
        chk("reset_last4", {31'h0, last_4}, 32'h0);
        chk("reset_q4", {28'h0, q_4}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vectors in order: vec 3 follows the all-ones carry and proves the final carry was dropped.
        for (int k = 0; k < 7; k++) begin
            rs1_en = vecs[k].rs1_en;
            imm_en = vecs[k].imm_en;
            run_word(4, vecs[k].rs1, vecs[k].imm, vecs[k].clr);
            chk($sformatf("v%0d_ext", k), ext_4, vecs[k].exp_sum);
            chk($sformatf("v%0d_adr", k), adr_4, {vecs[k].exp_sum[31:2], 2'b00});
            chk($sformatf("v%0d_lsb", k), {30'h0, lsb_4}, {30'h0, vecs[k].exp_lsb});
            chk($sformatf("v%0d_q_idle", k), {28'h0, q_4}, 32'h0);
        end
        rs1_en = 1'b1;
        imm_en = 1'b1;

        // MDU forcing of o_lsb: W=4 instance has MDU=1, W=2 instance has MDU=0.
        run_word(4, 32'h0000_1000, 32'h0000_07FF, 1'b0);
        run_word(2, 32'h0000_1001, 32'h0000_0003, 1'b1);
        chk("w2_clr_ext", ext_2, 32'h0000_1003);
        chk("w2_clr_lsb", {30'h0, lsb_2}, 32'd3);
        mdu_op = 1'b1;
        #1;
        chk("mdu_op1_lsb4", {30'h0, lsb_4}, 32'd0);
        chk("mdu_op1_lsb2_nomdu", {30'h0, lsb_2}, 32'd3);
        mdu_op = 1'b0;
        #1;
        chk("mdu_op0_lsb4", {30'h0, lsb_4}, 32'd3);

        // Shift mode, signed then unsigned.
        for (int s = 0; s < 2; s++) begin
            run_word(4, 32'h8000_000F, 32'h0, 1'b0);
            @(negedge clk);
            init = 1'b0;
            sh_signed = (s == 0);
            set_beat(4, 1'b1, 32'h0, 32'h0);
            #1;
            chk($sformatf("shift%0d_q", s), {28'h0, q_4}, 32'hF);
            @(negedge clk);
            set_beat(4, 1'b0, 32'h0, 32'h0);
            #1;
            chk($sformatf("shift%0d_ext", s), ext_4, (s == 0) ? 32'hF800_0000 : 32'h0800_0000);
        end
        sh_signed = 1'b0;

        // W=1: reset after 5 beats of a carry-heavy word, then a clean word.
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            init = 1'b1;
            cnt0 = (b == 0);
            set_beat(1, 1'b1, 32'hFFFF_FFFF >> b, 32'h1 >> b);
        end
        @(negedge clk);
        cnt0 = 1'b0;
        set_beat(1, 1'b1, 32'h1, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("w1_rst_ext", ext_1, 32'h0);
        chk("w1_rst_adr", adr_1, 32'h0);
        chk("w1_rst_lsb", {30'h0, lsb_1}, 32'h0);
        chk("w1_rst_last", {31'h0, last_1}, 32'h0);
        chk("w1_rst_q", {31'h0, q_1}, 32'h0);
        chk("w1_rst_ext4", ext_4, 32'h0);
        set_beat(1, 1'b0, 32'h0, 32'h0);
        init = 1'b0;
        #2;
        rst_n = 1'b1;
        run_word(1, 32'h89AB_CDEF, 32'h0123_4567, 1'b0);
        chk("w1_sum_ext", ext_1, 32'h8ACF_1356);
        chk("w1_sum_lsb", {30'h0, lsb_1}, 32'd2);
        chk("w1_sum_adr", adr_1, 32'h8ACF_1354);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
